sevenseg_reader: RTL
====================

SEVENSEG_READER -- requirements
Module: sevenseg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive sampled cycles a segment pair must hold before it is accepted (legal range 2..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 seg_ones  input  7  ones-digit segment pattern, bit0=a .. bit6=g, active-high.
REQ-005 seg_tens  input  7  tens-digit segment pattern, same encoding.
REQ-006 value  output  7  last accepted legal decoded value, 0..99 binary.
REQ-007 value_valid  output  1  high while value reflects a legal accepted display.
REQ-008 update  output  1  one-cycle pulse on each accepted (committed) new pattern pair.
REQ-009 illegal  output  1  one-cycle pulse when a committed pattern pair is not two legal digits.
REQ-010 seq_err  output  1  one-cycle pulse when a legal commit breaks the +1 mod 100 sequence.
REQ-011 wrap_count  output  8  count of 99->0 transitions, saturating at 255.

Function
REQ-012 Both segment buses shall be registered in a single input stage (in_q) every cycle.
REQ-013 If in_q differs from the candidate register, the candidate shall load in_q and the stability counter shall clear to 0.
REQ-014 If in_q equals the candidate, the stability counter shall increment, saturating at STABLE_CYCLES-1.
REQ-015 Commit shall occur on the edge where the counter equals STABLE_CYCLES-1, in_q equals the candidate, and the candidate differs from the last committed pair or nothing has been committed since reset.
REQ-016 Latency: a pair presented before sampling edge 1 and held shall produce update high after edge STABLE_CYCLES+2 (edge 6 at default).
REQ-017 Legal patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; all other codes, including blank, are illegal.
REQ-018 Legal commit: value = 10*tens+ones, value_valid=1, update pulse.
REQ-019 Illegal commit: update and illegal pulse together, value holds, value_valid=0, no seq_err, wrap_count unchanged.
REQ-020 Legal commit with value_valid previously 1: new=(prev+1) mod 100 -> no flag; new=0 from prev=99 -> wrap_count increments (saturating); new=0 from any other prev -> treated as user reset, no flag; any other new -> seq_err pulse.
REQ-021 Legal commit with value_valid previously 0 shall never raise seq_err nor touch wrap_count.
REQ-022 Glitches shorter than STABLE_CYCLES+1 sampled cycles shall produce no commit and no flag.
REQ-023 Returning to the previously committed pair after a glitch shall produce no update.
REQ-024 An input change on the commit edge shall not affect that commit; it starts a new candidate next edge.
REQ-025 update, illegal, seq_err shall each be high for exactly one cycle per event, never longer.

Reset
REQ-026 While reset is high: value=0, value_valid=0, update=0, illegal=0, seq_err=0, wrap_count=0, in_q=0, candidate=0, counter=0, committed flag=0.
REQ-027 Reset asserted mid-settle shall abort the pending commit; no pulse shall follow release.
REQ-028 After release, the first held pair commits per REQ-016 even if it equals 0000000/0000000.

Structure
REQ-029 Shared package sevenseg_pkg shall hold the ten segment constants and the 7-bit value width constant, shared with the stopwatch display encoder.
REQ-030 One combinational sub-module seg7_to_bcd (7-bit pattern -> 4-bit digit + legal flag) shall be instantiated twice.
REQ-031 The settle logic shall be an explicit FSM: IDLE (no commit yet), SETTLE (candidate counting), LOCKED (candidate equals committed).

Verification
REQ-032 Reset, hold tens=0111111 ones=1101101 -> update after edge 6, value=5, value_valid=1, seq_err=0.
REQ-033 Step 05->06->...->99->00 each held 8 cycles -> 95 updates, no seq_err, wrap_count=1 after the 00 commit.
REQ-034 From value 12, hold 15 -> seq_err pulse, value=15; then hold 00 -> no seq_err, wrap_count unchanged.
REQ-035 From value 40, 3-cycle glitch to 41 then back to 40 -> no update, no flags.
REQ-036 From value 40, hold ones=0000000 -> illegal and update pulse, value=40, value_valid=0; then hold 41 -> value=41, no seq_err.
REQ-037 Assert reset at counter=2 during settling -> all outputs 0, no update within 10 cycles of release while inputs unchanged beyond REQ-028 latency.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions used by the reader and the stopwatch display encoder.
package sevenseg_pkg;

  // Width of the decoded two-digit binary value (0..99).
  localparam int unsigned VALUE_W = 7;

  // Segment patterns, bit0=a .. bit6=g, active-high.
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  // Settle FSM: IDLE = nothing committed yet, SETTLE = candidate differs from
  // committed pair and is counting, LOCKED = candidate equals committed pair.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } settle_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one seven-segment pattern to a BCD digit plus legal flag.
import sevenseg_pkg::*;

module seg7_to_bcd (
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       legal
);

  // Exact-match lookup; anything outside the ten digit shapes is illegal.
  always_comb begin
    digit = '0;
    legal = 1'b1;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_reader.sv
// Reads a two-digit seven-segment display, debounces it and checks count sequence.
import sevenseg_pkg::*;

module sevenseg_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         seg_ones,
  input  logic [6:0]         seg_tens,
  output logic [VALUE_W-1:0] value,
  output logic               value_valid,
  output logic               update,
  output logic               illegal,
  output logic               seq_err,
  output logic [7:0]         wrap_count
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

  logic [13:0]   in_q, cand, committed;
  logic          in_q_vld, cand_vld;
  logic [3:0]    cnt;
  settle_state_t state;

  logic [13:0]   cand_nxt;
  logic          cand_vld_nxt;
  logic [3:0]    cnt_nxt;
  settle_state_t state_nxt;
  logic          commit;

  logic [3:0]         tens_d, ones_d;
  logic               tens_ok, ones_ok;
  logic [VALUE_W-1:0] new_val, exp_next;

  // Input stage; in_q_vld keeps the reset-value in_q from counting as a sample,
  // so a held 00/blank pair after reset settles with the same latency as any other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q     <= '0;
      in_q_vld <= 1'b0;
    end else begin
      in_q     <= {seg_tens, seg_ones};
      in_q_vld <= 1'b1;
    end
  end

  // Settle state, candidate and stability counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cand      <= '0;
      cand_vld  <= 1'b0;
      cnt       <= '0;
      committed <= '0;
    end else begin
      state    <= state_nxt;
      cand     <= cand_nxt;
      cand_vld <= cand_vld_nxt;
      cnt      <= cnt_nxt;
      if (commit)
        committed <= cand;
    end
  end

  // Next-state: reload candidate on change, count while stable, commit at CNT_MAX.
  always_comb begin
    state_nxt    = state;
    cand_nxt     = cand;
    cand_vld_nxt = cand_vld;
    cnt_nxt      = cnt;
    commit       = 1'b0;
    if (in_q_vld) begin
      if (!cand_vld || (in_q != cand)) begin
        cand_nxt     = in_q;
        cand_vld_nxt = 1'b1;
        cnt_nxt      = '0;
        if (state != ST_IDLE)
          state_nxt = (in_q == committed) ? ST_LOCKED : ST_SETTLE;
      end else begin
        if (cnt != CNT_MAX)
          cnt_nxt = 4'(cnt + 4'd1);
        if ((cnt == CNT_MAX) && (state != ST_LOCKED)) begin
          commit    = 1'b1;
          state_nxt = ST_LOCKED;
        end
      end
    end
  end

  seg7_to_bcd u_tens (.seg(cand[13:7]), .digit(tens_d), .legal(tens_ok));
  seg7_to_bcd u_ones (.seg(cand[6:0]),  .digit(ones_d), .legal(ones_ok));

  // Decoded candidate value and the value that continues the count.
  always_comb begin
    new_val  = 7'({3'b000, tens_d} * 7'd10) + {3'b000, ones_d};
    exp_next = (value == 7'd99) ? '0 : 7'(value + 7'd1);
  end

  // Commit outputs: value/valid update, sequence and wrap tracking, one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value       <= '0;
      value_valid <= 1'b0;
      update      <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      wrap_count  <= '0;
    end else begin
      update  <= 1'b0;
      illegal <= 1'b0;
      seq_err <= 1'b0;
      if (commit) begin
        update <= 1'b1;
        if (!(tens_ok && ones_ok)) begin
          illegal     <= 1'b1;
          value_valid <= 1'b0;
        end else begin
          value       <= new_val;
          value_valid <= 1'b1;
          if (value_valid) begin
            if ((new_val == '0) && (value == 7'd99)) begin
              if (wrap_count != 8'hFF)
                wrap_count <= 8'(wrap_count + 8'd1);
            end else if ((new_val != exp_next) && (new_val != '0)) begin
              seq_err <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
